// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone BRAM arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Low bit of field k in a flattened bus of w-bit fields.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin picker: first requester scanning upward from last+1 (mod N).
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    logic [LW:0]   w_sum;
    logic [LW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_sum = {1'b0, i_last} + (LW+1)'(i);
            if (w_sum >= (LW+1)'(N)) begin
                w_sum = w_sum - (LW+1)'(N);
            end
            w_idx = w_sum[LW-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Round-robin Wishbone B3 arbiter with cycle-locked grant and ack watchdog
// in front of a single shared slave.
module wb_bram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    output logic [NUM_MASTERS-1:0]              gnt_o,
    output logic                                busy_o
);

    localparam int N  = NUM_MASTERS;
    localparam int SW = sel_width(DATA_WIDTH);
    localparam int LW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam int WW = WDOG_EN ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WDOG_EN ? WW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WW-1:0] WD_MAX  = '1;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [LW-1:0] r_last;
    logic [LW-1:0] w_last_nxt;
    logic [WW-1:0] r_wdog;
    logic [WW-1:0] w_wdog_nxt;

    logic [N-1:0]            w_pick;
    logic                    w_pick_valid;
    logic [LW-1:0]           w_gidx;
    logic                    w_cyc;
    logic                    w_stb;
    logic                    w_we;
    logic [SW-1:0]           w_sel;
    logic [ADDR_WIDTH-1:0]   w_adr;
    logic [DATA_WIDTH-1:0]   w_dat;
    logic                    w_stb_raw;
    logic                    w_timeout;

    wb_arb_rr_pick #(
        .N  (N),
        .LW (LW)
    ) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_gnt   (w_pick),
        .o_valid (w_pick_valid)
    );

    // r_gnt is zero outside OWNED, so the mux also idles the slave side.
    always_comb begin
        w_gidx = '0;
        w_cyc  = 1'b0;
        w_stb  = 1'b0;
        w_we   = 1'b0;
        w_sel  = '0;
        w_adr  = '0;
        w_dat  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_gidx = LW'(i);
                w_cyc  = m_cyc_i[i];
                w_stb  = m_stb_i[i];
                w_we   = m_we_i[i];
                w_sel  = m_sel_i[slice_lo(i, SW) +: SW];
                w_adr  = m_adr_i[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
                w_dat  = m_dat_i[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign w_stb_raw = w_cyc & w_stb;
    assign w_timeout = WDOG_EN && w_stb_raw && !s_ack_i && !s_err_i
                       && (r_wdog == WD_LAST);

    assign s_cyc_o = w_cyc & ~w_timeout;
    assign s_stb_o = w_stb_raw & ~w_timeout;
    assign s_we_o  = w_we;
    assign s_sel_o = w_sel;
    assign s_adr_o = w_adr;
    assign s_dat_o = w_dat;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = r_gnt & {N{s_ack_i}};
    assign m_err_o = r_gnt & {N{s_err_i | w_timeout}};
    assign gnt_o   = r_gnt;
    assign busy_o  = (r_state == OWNED);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_wdog_nxt  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (!w_cyc || w_timeout) begin
                    w_gnt_nxt   = '0;
                    w_last_nxt  = w_gidx;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
        if (w_stb_raw && !s_ack_i && !s_err_i && !w_timeout) begin
            w_wdog_nxt = (r_wdog == WD_MAX) ? r_wdog : r_wdog + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= LW'(N - 1);
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter: two masters, watchdog of 4 cycles.
module tb_wb_bram_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc_i;
    logic [N-1:0]      m_stb_i;
    logic [N-1:0]      m_we_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SW-1:0]     s_sel_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;
    logic              s_err_i;
    logic [N-1:0]      gnt_o;
    logic              busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_bram_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_sel_i  (m_sel_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb,
                         input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat);
        m_cyc_i[k]            = cyc;
        m_stb_i[k]            = stb;
        m_we_i[k]             = we;
        m_sel_i[k*SW +: SW]   = stb ? 4'hF : 4'h0;
        m_adr_i[k*AW +: AW]   = adr;
        m_dat_i[k*DW +: DW]   = dat;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_sel_i = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_dat_i = 32'h1234_5678;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        #3;
        chk("rst_gnt",  gnt_o,   2'b00);
        chk("rst_busy", busy_o,  1'b0);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_sstb", s_stb_o, 1'b0);
        chk("rst_ack",  m_ack_o, 2'b00);
        chk("rst_err",  m_err_o, 2'b00);
        chk("rst_mdat", m_dat_o, 32'h1234_5678);
        tick();
        rst = 1'b0;

        // 1: single write from M0
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hEEEE_EEEE);
        settle();
        chk("t1_latency", gnt_o, 2'b00);
        tick();
        chk("t1_gnt",  gnt_o,   2'b01);
        chk("t1_busy", busy_o,  1'b1);
        chk("t1_sdat", s_dat_o, 32'hEEEE_EEEE);
        chk("t1_swe",  s_we_o,  1'b1);
        chk("t1_ssel", s_sel_o, 4'hF);
        chk("t1_scyc", s_cyc_o, 1'b1);
        s_ack_i = 1'b1;
        settle();
        chk("t1_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t1_rel_scyc", s_cyc_o, 1'b0);
        tick();
        chk("t1_idle", gnt_o, 2'b00);

        // 2: simultaneous request after reset
        rst = 1'b1;
        settle();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t2_gnt_m0", gnt_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t2_gap", gnt_o, 2'b00);
        tick();
        chk("t2_gnt_m1", gnt_o, 2'b10);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t2_idle", gnt_o, 2'b00);

        // 3: M1 burst locked against M0
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t3_gnt_m1", gnt_o, 2'b10);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_m(1, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
            s_ack_i = 1'b1;
            settle();
            chk("t3_ack",  m_ack_o, 2'b10);
            chk("t3_sadr", s_adr_o, 32'h100 + 32'(i * 4));
            chk("t3_lock", gnt_o,   2'b10);
            tick();
        end
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack_i = 1'b0;
        settle();
        chk("t3_noack", m_ack_o, 2'b00);
        tick();
        chk("t3_gap", gnt_o, 2'b00);
        tick();
        chk("t3_gnt_m0", gnt_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t3_idle", gnt_o, 2'b00);

        // 4: slave never acks
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        chk("t4_gnt", gnt_o, 2'b01);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_err",  m_err_o, (k == 3) ? 2'b01 : 2'b00);
            chk("t4_scyc", s_cyc_o, (k == 3) ? 1'b0 : 1'b1);
            tick();
        end
        chk("t4_busy", busy_o,  1'b0);
        chk("t4_gnt0", gnt_o,   2'b00);
        chk("t4_err0", m_err_o, 2'b00);
        tick();
        chk("t4_regnt", gnt_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t4_idle", gnt_o, 2'b00);

        // 5: reset in the middle of a transfer
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h80, 32'hABCD);
        tick();
        chk("t5_gnt_m1", gnt_o, 2'b10);
        s_ack_i = 1'b1;
        settle();
        chk("t5_ack", m_ack_o, 2'b10);
        rst = 1'b1;
        settle();
        chk("t5_scyc", s_cyc_o, 1'b0);
        chk("t5_sstb", s_stb_o, 1'b0);
        chk("t5_ack0", m_ack_o, 2'b00);
        chk("t5_err0", m_err_o, 2'b00);
        chk("t5_gnt0", gnt_o,   2'b00);
        chk("t5_busy", busy_o,  1'b0);
        rst = 1'b0;
        s_ack_i = 1'b0;
        tick();
        chk("t5_gnt_m0", gnt_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t5_idle", gnt_o, 2'b00);

        // 6: ack lands on the timeout cycle
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0);
        tick();
        chk("t6_gnt", gnt_o, 2'b01);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t6_pre_err", m_err_o, 2'b00);
            tick();
        end
        s_ack_i = 1'b1;
        settle();
        chk("t6_ack",  m_ack_o, 2'b01);
        chk("t6_err",  m_err_o, 2'b00);
        chk("t6_scyc", s_cyc_o, 1'b1);
        tick();
        s_ack_i = 1'b0;
        chk("t6_busy", busy_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t6_wdog", m_err_o, (k == 3) ? 2'b01 : 2'b00);
            tick();
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t6_idle", gnt_o, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
